// File: rtl/axi4_lite_master_rw.sv
// Single-outstanding command port to AXI4-Lite master bridge; write and read each take 3 edges with a zero-wait slave.
// VALIDs are held until their own handshake, and transfer is ignored while busy.
module axi4_lite_master_rw #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [STRB_WIDTH-1:0] WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic                  transfer,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    output logic                  busy,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            resp
);

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R
    } state_t;

    state_t state_q;

    // A channel counts as done once its VALID has dropped or is handshaking now.
    logic aw_done;
    logic w_done;

    assign aw_done = !AWVALID || AWREADY;
    assign w_done  = !WVALID  || WREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
            AWADDR  <= '0;
            AWVALID <= 1'b0;
            WDATA   <= '0;
            WSTRB   <= '0;
            WVALID  <= 1'b0;
            BREADY  <= 1'b0;
            ARADDR  <= '0;
            ARVALID <= 1'b0;
            RREADY  <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            rdata   <= '0;
            resp    <= 2'b00;
        end else begin
            ready <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (transfer) begin
                        busy <= 1'b1;
                        if (write) begin
                            AWADDR  <= addr;
                            WDATA   <= wdata;
                            WSTRB   <= wstrb;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            state_q <= WR_AW_W;
                        end else begin
                            ARADDR  <= addr;
                            ARVALID <= 1'b1;
                            state_q <= RD_AR;
                        end
                    end
                end
                WR_AW_W: begin
                    if (AWVALID && AWREADY) AWVALID <= 1'b0;
                    if (WVALID && WREADY)   WVALID  <= 1'b0;
                    if (aw_done && w_done) begin
                        BREADY  <= 1'b1;
                        state_q <= WR_B;
                    end
                end
                WR_B: begin
                    if (BVALID) begin
                        resp    <= BRESP;
                        ready   <= 1'b1;
                        BREADY  <= 1'b0;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RD_AR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state_q <= RD_R;
                    end
                end
                RD_R: begin
                    if (RVALID) begin
                        rdata   <= RDATA;
                        resp    <= RRESP;
                        ready   <= 1'b1;
                        RREADY  <= 1'b0;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master_rw.sv
// Bench for axi4_lite_master_rw: a configurable-latency slave on a 32-bit instance plus a zero-wait 64-bit instance.
// Expected completions are queued when a command is issued and retired on each ready pulse.
module tb_axi4_lite_master_rw;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;

    logic [3:0]  AWADDR, ARADDR, addr;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA, wdata, rdata;
    logic [3:0]  WSTRB, wstrb;
    logic [1:0]  BRESP, RRESP, resp;
    logic        transfer, write, busy, ready;

    logic [3:0]  AWADDR_w, ARADDR_w, addr_w;
    logic        AWVALID_w, AWREADY_w, WVALID_w, WREADY_w, BVALID_w, BREADY_w;
    logic        ARVALID_w, ARREADY_w, RVALID_w, RREADY_w;
    logic [63:0] WDATA_w, RDATA_w, wdata_w, rdata_w;
    logic [7:0]  WSTRB_w, wstrb_w;
    logic [1:0]  BRESP_w, RRESP_w, resp_w;
    logic        transfer_w, write_w, busy_w, ready_w;

    int total = 0;
    int bad = 0;

    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;

    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    int aw_cyc = 0, w_cyc = 0, b_cyc = 0, early_b = 0;
    int aw_hs = 0, ar_hs = 0, rdy_cnt = 0;
    logic [31:0] last_rdata = 32'h0;
    exp_t exp_q[$];

    axi4_lite_master_rw #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .transfer(transfer), .write(write), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .busy(busy), .ready(ready), .rdata(rdata), .resp(resp)
    );

    axi4_lite_master_rw #(.ADDR_WIDTH(4), .DATA_WIDTH(64)) dut_w (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR_w), .AWVALID(AWVALID_w), .AWREADY(AWREADY_w),
        .WDATA(WDATA_w), .WSTRB(WSTRB_w), .WVALID(WVALID_w), .WREADY(WREADY_w),
        .BRESP(BRESP_w), .BVALID(BVALID_w), .BREADY(BREADY_w),
        .ARADDR(ARADDR_w), .ARVALID(ARVALID_w), .ARREADY(ARREADY_w),
        .RDATA(RDATA_w), .RRESP(RRESP_w), .RVALID(RVALID_w), .RREADY(RREADY_w),
        .transfer(transfer_w), .write(write_w), .addr(addr_w), .wdata(wdata_w), .wstrb(wstrb_w),
        .busy(busy_w), .ready(ready_w), .rdata(rdata_w), .resp(resp_w)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave responses are decided on the falling edge, so a handshake seen here lands on the next rising edge.
    always @(negedge ACLK) begin
        exp_t e;
        if (AWVALID) begin AWREADY = (aw_wait >= aw_dly); aw_wait++; aw_cyc++; end
        else begin AWREADY = 1'b0; aw_wait = 0; end
        if (WVALID) begin WREADY = (w_wait >= w_dly); w_wait++; w_cyc++; end
        else begin WREADY = 1'b0; w_wait = 0; end
        if (BREADY) begin
            BVALID = (b_wait >= b_dly); b_wait++; b_cyc++;
            if (AWVALID || WVALID) early_b++;
        end else begin BVALID = 1'b0; b_wait = 0; end
        BRESP = BVALID ? cfg_bresp : 2'b00;
        if (ARVALID) begin ARREADY = (ar_wait >= ar_dly); ar_wait++; end
        else begin ARREADY = 1'b0; ar_wait = 0; end
        if (RREADY) begin RVALID = (r_wait >= r_dly); r_wait++; end
        else begin RVALID = 1'b0; r_wait = 0; end
        RDATA = RVALID ? cfg_rdata : 32'h0;
        RRESP = RVALID ? cfg_rresp : 2'b00;
        if (AWVALID && AWREADY) aw_hs++;
        if (ARVALID && ARREADY) ar_hs++;

        if (AWVALID || WVALID || ARVALID) begin
            check_eq("axi_cmd_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                if (AWVALID) check_eq("awaddr", AWADDR, exp_q[0].addr);
                if (WVALID) begin
                    check_eq("wdata", WDATA, exp_q[0].data);
                    check_eq("wstrb", WSTRB, exp_q[0].strb);
                end
                if (AWVALID || WVALID) check_eq("is_write", exp_q[0].wr, 1);
                if (ARVALID) begin
                    check_eq("araddr", ARADDR, exp_q[0].addr);
                    check_eq("is_read", exp_q[0].wr, 0);
                end
            end
        end

        if (ready) begin
            rdy_cnt++;
            check_eq("ready_has_cmd", exp_q.size() != 0, 1);
            check_eq("busy_at_ready", busy, 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("resp", resp, e.resp);
                if (!e.wr) last_rdata = e.rdata;
                check_eq("rdata", rdata, last_rdata);
            end
        end
    end

    task automatic issue(input bit wr, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] er, input logic [31:0] erd);
        exp_t e;
        int n = 0;
        while (busy && n < 300) begin @(posedge ACLK); #1; n++; end
        check_eq("issue_idle", busy, 0);
        transfer = 1'b1; write = wr; addr = a; wdata = d; wstrb = s;
        e.wr = wr; e.addr = a; e.data = d; e.strb = s; e.resp = er; e.rdata = erd;
        exp_q.push_back(e);
        @(posedge ACLK); #1;
        transfer = 1'b0; write = ~wr; addr = 4'hF; wdata = $urandom; wstrb = 4'h0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin @(posedge ACLK); #1; n++; end
        check_eq("done_in_time", exp_q.size(), 0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    initial begin
        int s_aw, s_w, s_b, s_eb, s_ahs, s_rhs, s_rdy, n;
        transfer = 0; write = 0; addr = 0; wdata = 0; wstrb = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        transfer_w = 0; write_w = 0; addr_w = 0; wdata_w = 0; wstrb_w = 0;
        AWREADY_w = 1; WREADY_w = 1; BVALID_w = 1; BRESP_w = 0;
        ARREADY_w = 0; RVALID_w = 0; RDATA_w = 0; RRESP_w = 0;

        repeat (3) @(posedge ACLK);
        #1;
        check_eq("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
        check_eq("rst_busy_ready", {busy, ready}, 0);
        check_eq("rst_axi_regs", {AWADDR, ARADDR, WDATA, WSTRB}, 0);
        check_eq("rst_rdata_resp", {rdata, resp}, 0);
        check_eq("rst_w64", {WSTRB_w, AWVALID_w, busy_w}, 0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;

        // Zero-wait write
        s_aw = aw_cyc; s_w = w_cyc; s_b = b_cyc; s_rdy = rdy_cnt;
        issue(1, 4'h4, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0);
        wait_done();
        check_eq("t1_aw_cycles", aw_cyc - s_aw, 1);
        check_eq("t1_w_cycles", w_cyc - s_w, 1);
        check_eq("t1_bready_cycles", b_cyc - s_b, 1);
        check_eq("t1_ready_pulses", rdy_cnt - s_rdy, 1);
        check_eq("t1_busy_after", busy, 0);

        // AWREADY late, WREADY immediate
        aw_dly = 3;
        s_aw = aw_cyc; s_w = w_cyc; s_b = b_cyc; s_eb = early_b;
        issue(1, 4'h4, 32'hA5A50001, 4'h3, 2'b00, 32'h0);
        wait_done();
        aw_dly = 0;
        check_eq("t2_aw_cycles", aw_cyc - s_aw, 4);
        check_eq("t2_w_cycles", w_cyc - s_w, 1);
        check_eq("t2_bready_cycles", b_cyc - s_b, 1);
        check_eq("t2_bready_early", early_b - s_eb, 0);

        // Read with RVALID delayed
        r_dly = 2; cfg_rdata = 32'h12345678;
        s_rdy = rdy_cnt; s_rhs = ar_hs;
        issue(0, 4'h8, 32'h0, 4'h0, 2'b00, 32'h12345678);
        wait_done();
        r_dly = 0;
        check_eq("t3_ready_pulses", rdy_cnt - s_rdy, 1);
        check_eq("t3_ar_hs", ar_hs - s_rhs, 1);
        check_eq("t3_rdata_held", rdata, 32'h12345678);

        // Error responses
        cfg_bresp = 2'b10;
        issue(1, 4'hC, 32'h0000FFFF, 4'h1, 2'b10, 32'h0);
        wait_done();
        cfg_bresp = 2'b00;
        check_eq("t4_bresp_held", resp, 2'b10);
        cfg_rresp = 2'b11; cfg_rdata = 32'hCAFEF00D;
        issue(0, 4'h0, 32'h0, 4'h0, 2'b11, 32'hCAFEF00D);
        wait_done();
        cfg_rresp = 2'b00;
        check_eq("t4_rresp_held", resp, 2'b11);

        // transfer pulses while busy must be ignored
        aw_dly = 5;
        s_ahs = aw_hs; s_rhs = ar_hs; s_rdy = rdy_cnt;
        issue(1, 4'h0, 32'h11112222, 4'hF, 2'b00, 32'h0);
        repeat (3) begin
            transfer = 1'b1; write = 1'b0; addr = 4'hC;
            @(posedge ACLK); #1;
            transfer = 1'b0;
            @(posedge ACLK); #1;
        end
        wait_done();
        aw_dly = 0;
        check_eq("t5_aw_hs", aw_hs - s_ahs, 1);
        check_eq("t5_ar_hs", ar_hs - s_rhs, 0);
        check_eq("t5_ready_pulses", rdy_cnt - s_rdy, 1);

        // Back-to-back write then read
        cfg_rdata = 32'h0BADBEEF;
        s_rdy = rdy_cnt;
        issue(1, 4'h4, 32'h55AA55AA, 4'h5, 2'b00, 32'h0);
        issue(0, 4'h8, 32'h0, 4'h0, 2'b00, 32'h0BADBEEF);
        wait_done();
        check_eq("t5_b2b_pulses", rdy_cnt - s_rdy, 2);

        // 64-bit instance, upper-half strobes, BVALID parked high before BREADY
        transfer_w = 1'b1; write_w = 1'b1; addr_w = 4'h4;
        wdata_w = 64'h0123456789ABCDEF; wstrb_w = 8'hF0;
        @(posedge ACLK); #1;
        transfer_w = 1'b0; wstrb_w = 8'h00; wdata_w = 64'h0;
        check_eq("w64_valids", {AWVALID_w, WVALID_w, BREADY_w}, 3'b110);
        check_eq("w64_wstrb", WSTRB_w, 8'hF0);
        check_eq("w64_wdata", WDATA_w, 64'h0123456789ABCDEF);
        check_eq("w64_awaddr", AWADDR_w, 4'h4);
        n = 0;
        while (!ready_w && n < 20) begin @(posedge ACLK); #1; n++; end
        check_eq("w64_ready", ready_w, 1);
        check_eq("w64_latency", n, 2);
        check_eq("w64_resp_busy", {resp_w, busy_w}, 0);
        @(posedge ACLK); #1;
        check_eq("w64_ready_1cyc", ready_w, 0);

        // Reset while waiting for RVALID
        r_dly = 1000;
        s_rdy = rdy_cnt;
        issue(0, 4'h8, 32'h0, 4'h0, 2'b00, 32'h0);
        n = 0;
        while (!RREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        check_eq("t6_rready_seen", RREADY, 1);
        #2 ARESET = 1'b1;
        #1;
        check_eq("t6_rready_async", RREADY, 0);
        check_eq("t6_busy_async", busy, 0);
        exp_q.delete();
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
        r_dly = 0;
        repeat (5) @(posedge ACLK);
        #1;
        check_eq("t6_no_ready", rdy_cnt - s_rdy, 0);
        check_eq("t6_idle", {busy, RREADY, ARVALID}, 0);
        check_eq("t6_rdata_cleared", rdata, 0);

        // Recovery after reset
        cfg_rdata = 32'h00000077;
        s_rdy = rdy_cnt;
        issue(0, 4'h4, 32'h0, 4'h0, 2'b00, 32'h00000077);
        wait_done();
        check_eq("t7_ready_pulses", rdy_cnt - s_rdy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
